// File: rtl/tdm_demux_4.sv
// tdm_demux_4: splits a 4-slot TDM word stream into four registered lanes.
// Optional TDM_FRAME_ERR_EN adds a premature-sof error pulse and counter.
module tdm_demux_4 #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   input  logic             in_sof,
   output logic             in_ready,
   output logic [WIDTH-1:0] y1,
   output logic [WIDTH-1:0] y2,
   output logic [WIDTH-1:0] y3,
   output logic [WIDTH-1:0] y4,
   output logic [1:0]       sel,
   output logic             out_valid,
   input  logic             out_ready
`ifdef TDM_FRAME_ERR_EN
   ,
   output logic             frame_err,
   output logic [7:0]       err_count
`endif
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FULL    = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_state_nx;
   logic [1:0]       r_sel;
   logic [1:0]       w_sel_nx;
   logic [WIDTH-1:0] r_y [4];
   logic             w_acc;
   logic             w_wr;
   logic [1:0]       w_idx;
   logic             w_perr;

   assign in_ready  = (r_state != FULL);
   assign out_valid = (r_state == FULL);
   assign sel       = r_sel;
   assign w_acc     = in_valid && in_ready;
   assign y1        = r_y[0];
   assign y2        = r_y[1];
   assign y3        = r_y[2];
   assign y4        = r_y[3];

   // State and slot index registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_sel   <= 2'd0;
      end else begin
         r_state <= w_state_nx;
         r_sel   <= w_sel_nx;
      end
   end

   // Next state, slot index and lane write decode
   always_comb begin
      w_state_nx = r_state;
      w_sel_nx   = r_sel;
      w_wr       = 1'b0;
      w_idx      = r_sel;
      w_perr     = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (w_acc && in_sof) begin
               w_wr       = 1'b1;
               w_idx      = 2'd0;
               w_sel_nx   = 2'd1;
               w_state_nx = COLLECT;
            end
         end
         COLLECT: begin
            if (w_acc) begin
               w_wr = 1'b1;
               if (in_sof) begin
                  // restart: the partial frame is abandoned
                  w_idx    = 2'd0;
                  w_sel_nx = 2'd1;
                  w_perr   = 1'b1;
               end else begin
                  w_idx    = r_sel;
                  w_sel_nx = r_sel + 2'd1;
                  if (r_sel == 2'd3) begin
                     w_state_nx = FULL;
                  end
               end
            end
         end
         FULL: begin
            if (out_ready) begin
               w_state_nx = IDLE;
            end
         end
         default: begin
            w_state_nx = IDLE;
            w_sel_nx   = 2'd0;
         end
      endcase
   end

   // Lane registers; only the addressed lane is loaded
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            r_y[i] <= '0;
         end
      end else if (w_wr) begin
         r_y[w_idx] <= in_data;
      end
   end

`ifdef TDM_FRAME_ERR_EN
   logic [7:0] r_err_count;
   logic       r_frame_err;

   assign frame_err = r_frame_err;
   assign err_count = r_err_count;

   // Error pulse and saturating counter for premature sof
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_err <= 1'b0;
         r_err_count <= 8'd0;
      end else begin
         r_frame_err <= w_perr;
         if (w_perr && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
         end
      end
   end
`else
   logic w_unused;
   assign w_unused = w_perr;
`endif

endmodule

// File: tb/tb_tdm_demux_4.sv
// tb_tdm_demux_4: directed self-checking bench for tdm_demux_4.
// Covers TDM_FRAME_ERR_EN checks when that macro is defined.
module tb_tdm_demux_4;

   localparam int W = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] in_data;
   logic         in_valid;
   logic         in_sof;
   logic         in_ready;
   logic [W-1:0] y1, y2, y3, y4;
   logic [1:0]   sel;
   logic         out_valid;
   logic         out_ready;
`ifdef TDM_FRAME_ERR_EN
   logic         frame_err;
   logic [7:0]   err_count;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   tdm_demux_4 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_sof    (in_sof),
      .in_ready  (in_ready),
      .y1        (y1),
      .y2        (y2),
      .y3        (y3),
      .y4        (y4),
      .sel       (sel),
      .out_valid (out_valid),
      .out_ready (out_ready)
`ifdef TDM_FRAME_ERR_EN
      ,
      .frame_err (frame_err),
      .err_count (err_count)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [W-1:0] d, input logic s);
      in_valid = 1'b1;
      in_data  = d;
      in_sof   = s;
      step();
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = '0;
   endtask

   task automatic lanes(input string tag, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic [W-1:0] d);
      chk({tag, "_y1"}, 32'(y1), 32'(a));
      chk({tag, "_y2"}, 32'(y2), 32'(b));
      chk({tag, "_y3"}, 32'(y3), 32'(c));
      chk({tag, "_y4"}, 32'(y4), 32'(d));
   endtask

   task automatic drain(input string tag);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk({tag, "_ov0"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy1"}, 32'(in_ready), 32'd1);
      chk({tag, "_sel0"}, 32'(sel), 32'd0);
   endtask

   initial begin
      rst       = 1'b1;
      in_data   = '0;
      in_valid  = 1'b0;
      in_sof    = 1'b0;
      out_ready = 1'b0;
      step();
      step();
      rst = 1'b0;
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_rdy", 32'(in_ready), 32'd1);
      chk("rst_sel", 32'(sel), 32'd0);
      lanes("rst", 16'h0, 16'h0, 16'h0, 16'h0);
`ifdef TDM_FRAME_ERR_EN
      chk("rst_ferr", 32'(frame_err), 32'd0);
      chk("rst_ecnt", 32'(err_count), 32'd0);
`endif

      // normal frame
      send(16'h1111, 1'b1);
      chk("n_sel1", 32'(sel), 32'd1);
      send(16'h2222, 1'b0);
      send(16'h3333, 1'b0);
      chk("n_sel3", 32'(sel), 32'd3);
      chk("n_ov_early", 32'(out_valid), 32'd0);
      send(16'h4444, 1'b0);
      chk("n_ov", 32'(out_valid), 32'd1);
      chk("n_rdy0", 32'(in_ready), 32'd0);
      chk("n_selw", 32'(sel), 32'd0);
      lanes("n", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      step();
      chk("n_ov_hold", 32'(out_valid), 32'd1);
      drain("n");

      // out_ready while idle is ignored
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk("ign_rdy", 32'(in_ready), 32'd1);
      chk("ign_ov", 32'(out_valid), 32'd0);

      // garbage before sof, gaps inside frame
      send(16'hDEAD, 1'b0);
      chk("g_sel", 32'(sel), 32'd0);
      lanes("g0", 16'h1111, 16'h2222, 16'h3333, 16'h4444);
      send(16'hA001, 1'b1);
      step();
      step();
      step();
      chk("g_gap_sel", 32'(sel), 32'd1);
      chk("g_gap_ov", 32'(out_valid), 32'd0);
      send(16'hA002, 1'b0);
      send(16'hA003, 1'b0);
      send(16'hA004, 1'b0);
      chk("g_ov", 32'(out_valid), 32'd1);
      lanes("g", 16'hA001, 16'hA002, 16'hA003, 16'hA004);
      drain("g");

      // premature sof
      send(16'h0001, 1'b1);
      send(16'h0002, 1'b0);
      send(16'h0BAD, 1'b1);
      chk("p_sel", 32'(sel), 32'd1);
      chk("p_y1", 32'(y1), 32'h0BAD);
      chk("p_y2keep", 32'(y2), 32'h0002);
`ifdef TDM_FRAME_ERR_EN
      chk("p_ferr1", 32'(frame_err), 32'd1);
`endif
      send(16'h0C02, 1'b0);
`ifdef TDM_FRAME_ERR_EN
      chk("p_ferr0", 32'(frame_err), 32'd0);
`endif
      send(16'h0C03, 1'b0);
      send(16'h0C04, 1'b0);
      chk("p_ov", 32'(out_valid), 32'd1);
      lanes("p", 16'h0BAD, 16'h0C02, 16'h0C03, 16'h0C04);
`ifdef TDM_FRAME_ERR_EN
      chk("p_ecnt", 32'(err_count), 32'd1);
`endif

      // backpressure: input offered while full is refused
      in_valid = 1'b1;
      in_sof   = 1'b1;
      in_data  = 16'hFFFF;
      for (int i = 0; i < 5; i++) begin
         chk("bp_rdy", 32'(in_ready), 32'd0);
         step();
      end
      in_valid = 1'b0;
      in_sof   = 1'b0;
      chk("bp_ov", 32'(out_valid), 32'd1);
      chk("bp_sel", 32'(sel), 32'd0);
      lanes("bp", 16'h0BAD, 16'h0C02, 16'h0C03, 16'h0C04);
      drain("bp");

      // reset mid-frame
      send(16'h5555, 1'b1);
      send(16'h6666, 1'b0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("r_sel", 32'(sel), 32'd0);
      chk("r_ov", 32'(out_valid), 32'd0);
      lanes("r", 16'h0, 16'h0, 16'h0, 16'h0);
      step();
      chk("r_ov2", 32'(out_valid), 32'd0);
      send(16'h7771, 1'b1);
      send(16'h7772, 1'b0);
      send(16'h7773, 1'b0);
      send(16'h7774, 1'b0);
      chk("r2_ov", 32'(out_valid), 32'd1);
      lanes("r2", 16'h7771, 16'h7772, 16'h7773, 16'h7774);
      drain("r2");

`ifdef TDM_FRAME_ERR_EN
      // saturation of the error counter
      rst = 1'b1;
      step();
      rst = 1'b0;
      send(16'h0100, 1'b1);
      for (int i = 0; i < 300; i++) begin
         send(16'(i), 1'b1);
      end
      step();
      chk("sat_ecnt", 32'(err_count), 32'd255);
      chk("sat_sel", 32'(sel), 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
